// File: rtl/riscv_mc_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, FSM states,
// ALUOp/ALU control codes and the bundle of Moore control outputs.
package riscv_mc_controller_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_controller_aludec.sv
// ALU decoder: maps ALUOp plus funct fields to the 3-bit ALU control code.
import riscv_mc_controller_pkg::*;

module riscv_mc_controller_aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves alu_control unassigned (no latch).
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing lw/sw/R/I/beq/jal over
// 3-5 cycles, with combinational ALU and immediate decode.
import riscv_mc_controller_pkg::*;

module riscv_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:                 state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:                state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:  state_d = S_ALUWB;
      default:                  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      S_MEMREAD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_JAL: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_update = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  riscv_mc_controller_aludec u_aludec (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (ctrl.alu_op),
    .alu_control (alu_control)
  );

  // Branch resolution uses the ALU zero flag of the same cycle.
  assign pc_write   = ctrl.pc_update | (ctrl.branch & zero);
  assign adr_src    = ctrl.adr_src;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign reg_write  = ctrl.reg_write;
  assign imm_src    = imm_src_of(op);
  assign state      = state_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench: an instruction-level model (class + cycle index) predicts
// every output each cycle; directed runs pin the model with literal expectations.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [3:0] obs_st  [0:4];
  logic       obs_rw  [0:4];
  logic       obs_mw  [0:4];
  logic       obs_pcw [0:4];
  logic [2:0] obs_alu [0:4];

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
    .imm_src(imm_src), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction length in cycles and the state visited at each cycle index.
  function automatic int instr_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input logic [6:0] o, input int i);
    logic [3:0] seq [0:4];
    seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd0; seq[3] = 4'd0; seq[4] = 4'd0;
    case (o)
      7'b0000011: begin seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4; end
      7'b0100011: begin seq[2] = 4'd2; seq[3] = 4'd5; end
      7'b0110011: begin seq[2] = 4'd6; seq[3] = 4'd7; end
      7'b0010011: begin seq[2] = 4'd8; seq[3] = 4'd7; end
      7'b1101111: begin seq[2] = 4'd9; seq[3] = 4'd7; end
      7'b1100011: seq[2] = 4'd10;
      default: ;
    endcase
    return seq[i];
  endfunction

  // Operation selected by funct fields: sub only for R-type with funct7b5.
  function automatic logic [2:0] funct_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic compare_all(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int i, input logic z);
    logic e_adr = 0, e_mw = 0, e_ir = 0, e_rw = 0, e_pcw = 0;
    logic [1:0] e_rs = 0, e_a = 0, e_b = 0, e_imm;
    logic [2:0] e_alu = 0;
    int n = instr_len(o);
    bit last = (i == n - 1);
    if (i == 0) begin
      e_ir = 1; e_b = 2'b10; e_rs = 2'b10; e_pcw = 1;
    end else if (i == 1) begin
      e_a = 2'b01; e_b = 2'b01;
    end else begin
      case (o)
        7'b0000011, 7'b0100011: begin
          if (i == 2) begin e_a = 2'b10; e_b = 2'b01; end
          else if (i == 3) begin e_adr = 1; e_mw = (o == 7'b0100011); end
          else begin e_rs = 2'b01; e_rw = 1; end
        end
        7'b0110011, 7'b0010011: begin
          if (i == 2) begin
            e_a = 2'b10; e_b = (o == 7'b0110011) ? 2'b00 : 2'b01;
            e_alu = funct_alu(o == 7'b0110011, f3, f7);
          end
          e_rw = last;
        end
        7'b1101111: begin
          if (i == 2) begin e_a = 2'b01; e_b = 2'b10; e_pcw = 1; end
          e_rw = last;
        end
        7'b1100011: begin e_a = 2'b10; e_alu = 3'b001; e_pcw = z; end
        default: ;
      endcase
    end
    e_imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
            (o == 7'b1101111) ? 2'b11 : 2'b00;
    check("state",       state,       exp_state(o, i));
    check("pc_write",    pc_write,    e_pcw);
    check("adr_src",     adr_src,     e_adr);
    check("mem_write",   mem_write,   e_mw);
    check("ir_write",    ir_write,    e_ir);
    check("result_src",  result_src,  e_rs);
    check("alu_src_a",   alu_src_a,   e_a);
    check("alu_src_b",   alu_src_b,   e_b);
    check("alu_control", alu_control, e_alu);
    check("reg_write",   reg_write,   e_rw);
    check("imm_src",     imm_src,     e_imm);
  endtask

  // Entry and exit: 1 time unit after a rising edge with the DUT in FETCH.
  // zmode: 0/1 force zero, 2 random every cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    int n = instr_len(o);
    for (int k = 0; k < 5; k++) begin
      obs_st[k] = 4'hf; obs_rw[k] = 1'bx; obs_mw[k] = 1'bx; obs_pcw[k] = 1'bx; obs_alu[k] = 3'bx;
    end
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < n; i++) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #3;
      compare_all(o, f3, f7, i, zero);
      obs_st[i] = state; obs_rw[i] = reg_write; obs_mw[i] = mem_write;
      obs_pcw[i] = pc_write; obs_alu[i] = alu_control;
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] ops [0:5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    check("rst_state",    state,     4'd0);
    check("rst_ir_write", ir_write,  1'b1);
    check("rst_pc_write", pc_write,  1'b1);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_reg_write", reg_write, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(7'b0000011, 3'b010, 1'b0, 2);
    check("lw_states", {obs_st[4], obs_st[3], obs_st[2], obs_st[1], obs_st[0]},
          {4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
    check("lw_reg_write", {obs_rw[4], obs_rw[3], obs_rw[2], obs_rw[1], obs_rw[0]}, 5'b10000);

    run_instr(7'b0100011, 3'b010, 1'b0, 2);
    check("sw_states", {obs_st[3], obs_st[2], obs_st[1], obs_st[0]}, {4'd5, 4'd2, 4'd1, 4'd0});
    check("sw_mem_write", {obs_mw[3], obs_mw[2], obs_mw[1], obs_mw[0]}, 4'b1000);

    run_instr(7'b0110011, 3'b000, 1'b1, 2);
    check("r_sub", obs_alu[2], 3'b001);
    run_instr(7'b0110011, 3'b111, 1'b0, 2);
    check("r_and", obs_alu[2], 3'b010);
    run_instr(7'b0010011, 3'b000, 1'b1, 2);
    check("addi_not_sub", obs_alu[2], 3'b000);

    run_instr(7'b1100011, 3'b000, 1'b0, 1);
    check("beq_taken_pcw", {obs_pcw[2], obs_pcw[1], obs_pcw[0]}, 3'b101);
    run_instr(7'b1100011, 3'b000, 1'b0, 0);
    check("beq_nt_pcw", {obs_pcw[2], obs_pcw[1], obs_pcw[0]}, 3'b001);
    check("beq_nt_state", state, 4'd0);

    run_instr(7'b1101111, 3'b000, 1'b0, 2);
    check("jal_states", {obs_st[3], obs_st[2], obs_st[1], obs_st[0]}, {4'd7, 4'd9, 4'd1, 4'd0});
    check("jal_pcw", {obs_pcw[3], obs_pcw[2], obs_pcw[1], obs_pcw[0]}, 4'b0101);
    check("jal_rw",  {obs_rw[3], obs_rw[2], obs_rw[1], obs_rw[0]}, 4'b1000);

    run_instr(7'b1111111, 3'b000, 1'b0, 2);
    check("nop_states", {obs_st[1], obs_st[0]}, {4'd1, 4'd0});
    check("nop_decode_writes", {obs_rw[1], obs_mw[1], obs_pcw[1]}, 3'b000);

    // Abort a store in MEMWRITE with an asynchronous reset pulse.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3 compare_all(op, funct3, funct7b5, i, zero);
      @(posedge clk); #1;
    end
    #2;
    check("abort_pre_state", state, 4'd5);
    check("abort_pre_mw", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_state", state, 4'd0);
    check("abort_mw", mem_write, 1'b0);
    check("abort_rw", reg_write, 1'b0);
    check("abort_ir", ir_write, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 400; t++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
